// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the EX/MEM -> MEM stage: store/load size options and
// the memory-access FSM states, plus the access-size and alignment helpers.
package mem_access_stage_pkg;

    localparam logic [1:0] SAVE_SW  = 2'b00;
    localparam logic [1:0] SAVE_SH  = 2'b01;
    localparam logic [1:0] SAVE_SB  = 2'b10;

    localparam logic [2:0] LOAD_LW  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LHU = 3'b010;
    localparam logic [2:0] LOAD_LB  = 3'b011;
    localparam logic [2:0] LOAD_LBU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } acc_size_e;

    // Unlisted encodings (SAVE 11, LOAD 101..111) fall back to word accesses.
    function automatic acc_size_e access_size(input logic       is_store,
                                              input logic [1:0] save_opt,
                                              input logic [2:0] load_opt);
        acc_size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            if (save_opt == SAVE_SH)      sz = SZ_HALF;
            else if (save_opt == SAVE_SB) sz = SZ_BYTE;
        end else begin
            if (load_opt == LOAD_LH || load_opt == LOAD_LHU)      sz = SZ_HALF;
            else if (load_opt == LOAD_LB || load_opt == LOAD_LBU) sz = SZ_BYTE;
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] addr_lo);
        return ((sz == SZ_WORD) && (addr_lo != 2'b00)) ||
               ((sz == SZ_HALF) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store data replication/byte enables and
// load lane selection with sign or zero extension.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  save_opt_i,
    input  logic [2:0]  load_opt_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wdata_o = store_data_i;
        be_o    = '1;
        case (save_opt_i)
            SAVE_SH: begin
                wdata_o = {2{store_data_i[15:0]}};
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            SAVE_SB: begin
                wdata_o = {4{store_data_i[7:0]}};
                be_o    = 4'b0001 << addr_lo_i;
            end
            default: begin
                wdata_o = store_data_i;
                be_o    = '1;
            end
        endcase
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = load_word_i[7:0];
            2'd1:    byte_sel = load_word_i[15:8];
            2'd2:    byte_sel = load_word_i[23:16];
            default: byte_sel = load_word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];

        case (load_opt_i)
            LOAD_LH:  load_data_o = {{16{half_sel[15]}}, half_sel};
            LOAD_LHU: load_data_o = {16'h0000, half_sel};
            LOAD_LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: load_data_o = {24'h000000, byte_sel};
            default:  load_data_o = load_word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory req/ack access, stalls the front
// end while it is in flight, and holds the MEM/WB write-back registers.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      M_RegWrite,
    input  logic                      M_MemWrite,
    input  logic                      M_MemtoReg,
    input  logic [4:0]                M_WriteReg,
    input  logic [31:0]               M_Qb,
    input  logic [31:0]               M_ALUanswer,
    input  logic [2:0]                M_load_option,
    input  logic [1:0]                M_save_option,
    mem_access_stage_if.master        dmem,
    output logic                      Mem_Stall,
    output logic                      Mem_Err,
    output logic                      W_RegWrite,
    output logic [4:0]                W_WriteReg,
    output logic [31:0]               W_Result
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_reg_q, wb_reg_d;
    logic [31:0]       wb_res_q, wb_res_d;

    logic              stall_c, err_c;
    logic              is_access, is_store, is_load, misaligned;
    logic [31:0]       fmt_wdata, ld_data;
    logic [3:0]        fmt_be;

    assign is_store   = M_MemWrite;
    assign is_load    = M_MemtoReg & ~M_MemWrite;
    assign is_access  = M_MemWrite | M_MemtoReg;
    assign misaligned = is_access &
                        is_misaligned(access_size(is_store, M_save_option, M_load_option),
                                      M_ALUanswer[1:0]);

    mem_lane_align u_lane (
        .save_opt_i   (M_save_option),
        .load_opt_i   (M_load_option),
        .addr_lo_i    (M_ALUanswer[1:0]),
        .store_data_i (M_Qb),
        .load_word_i  (rdata_q),
        .wdata_o      (fmt_wdata),
        .be_o         (fmt_be),
        .load_data_o  (ld_data)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        req_d    = req_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wb_we_d  = wb_we_q;
        wb_reg_d = wb_reg_q;
        wb_res_d = wb_res_q;
        stall_c  = 1'b0;
        err_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wb_reg_d = M_WriteReg;
                wb_res_d = M_ALUanswer;
                if (is_access && !misaligned) begin
                    // Launch the access; the W stage sees a bubble meanwhile.
                    stall_c = 1'b1;
                    wb_we_d = 1'b0;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    be_d    = is_store ? fmt_be : 4'b1111;
                    addr_d  = {M_ALUanswer[31:2], 2'b00};
                    wdata_d = fmt_wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_REQ;
                end else begin
                    wb_we_d = M_RegWrite & ~misaligned;
                    err_c   = misaligned;
                end
            end
            ST_REQ: begin
                stall_c = 1'b1;
                if (dmem.dmem_ack) begin
                    rdata_d = dmem.dmem_rdata;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (ACK_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                err_c    = err_q;
                wb_we_d  = M_RegWrite & ~err_q;
                wb_reg_d = M_WriteReg;
                wb_res_d = is_load ? ld_data : M_ALUanswer;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wb_we_q  <= 1'b0;
            wb_reg_q <= '0;
            wb_res_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wb_we_q  <= wb_we_d;
            wb_reg_q <= wb_reg_d;
            wb_res_q <= wb_res_d;
        end
    end

    // Reset gates the combinational stall/error so they drop immediately.
    assign Mem_Stall       = stall_c & Reset;
    assign Mem_Err         = err_c & Reset;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign W_RegWrite      = wb_we_q;
    assign W_WriteReg      = wb_reg_q;
    assign W_Result        = wb_res_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: byte-addressed reference memory,
// randomized instruction stream, variable-latency memory responder.
module tb_mem_access_stage;

    localparam int ACK_TO = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        M_RegWrite, M_MemWrite, M_MemtoReg;
    logic [4:0]  M_WriteReg;
    logic [31:0] M_Qb, M_ALUanswer;
    logic [2:0]  M_load_option;
    logic [1:0]  M_save_option;
    logic        Mem_Stall, Mem_Err, W_RegWrite;
    logic [4:0]  W_WriteReg;
    logic [31:0] W_Result;

    mem_access_stage_if dmem_bus ();

    mem_access_stage #(.ACK_TIMEOUT(ACK_TO)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .M_RegWrite    (M_RegWrite),
        .M_MemWrite    (M_MemWrite),
        .M_MemtoReg    (M_MemtoReg),
        .M_WriteReg    (M_WriteReg),
        .M_Qb          (M_Qb),
        .M_ALUanswer   (M_ALUanswer),
        .M_load_option (M_load_option),
        .M_save_option (M_save_option),
        .dmem          (dmem_bus),
        .Mem_Stall     (Mem_Stall),
        .Mem_Err       (Mem_Err),
        .W_RegWrite    (W_RegWrite),
        .W_WriteReg    (W_WriteReg),
        .W_Result      (W_Result)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rw;
        logic [4:0]  wreg;
        logic [31:0] res;
        logic        chk_res;
        logic        err;
        int          stall;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    exp_t expq[$];
    bus_t busq[$];
    int   total = 0;
    int   bad = 0;
    logic drv_valid = 1'b0;
    logic mon_en = 1'b1;
    int   cur_wait = 0;
    logic [7:0] ref_bytes [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_nop();
        M_RegWrite = 0; M_MemWrite = 0; M_MemtoReg = 0; M_WriteReg = 0;
        M_Qb = 0; M_ALUanswer = 0; M_load_option = 0; M_save_option = 0;
    endtask

    // Memory responder: acks after cur_wait REQ cycles, random spurious acks otherwise.
    initial begin
        logic [31:0] phys_mem [16];
        int rcnt;
        rcnt = 0;
        for (int k = 0; k < 64; k++) phys_mem[k/4][8*(k%4) +: 8] = 8'(k * 37 + 5);
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = '0;
        forever begin
            @(negedge Clk);
            if (dmem_bus.dmem_req === 1'b1) begin
                if (rcnt == cur_wait) begin
                    dmem_bus.dmem_ack = 1'b1;
                    if (dmem_bus.dmem_we)
                        for (int j = 0; j < 4; j++)
                            if (dmem_bus.dmem_be[j])
                                phys_mem[dmem_bus.dmem_addr[5:2]][8*j +: 8] = dmem_bus.dmem_wdata[8*j +: 8];
                    dmem_bus.dmem_rdata = phys_mem[dmem_bus.dmem_addr[5:2]];
                end else begin
                    dmem_bus.dmem_ack   = 1'b0;
                    dmem_bus.dmem_rdata = $urandom;
                end
                rcnt++;
            end else begin
                rcnt = 0;
                dmem_bus.dmem_ack   = ($urandom_range(0, 7) == 0);
                dmem_bus.dmem_rdata = $urandom;
            end
        end
    end

    // Monitor: checks bus requests, stall length, error pulse and write-back.
    initial begin
        int   stall_cnt;
        bit   pend_v, req_seen, cb_v;
        exp_t pend, e;
        bus_t cb;
        stall_cnt = 0; pend_v = 0; req_seen = 0; cb_v = 0;
        forever begin
            @(negedge Clk);
            if (!mon_en || !Reset) begin
                stall_cnt = 0; pend_v = 0; req_seen = 0; cb_v = 0;
            end else begin
                if (pend_v) begin
                    chk("W_RegWrite", {31'b0, W_RegWrite}, {31'b0, pend.rw});
                    chk("W_WriteReg", {27'b0, W_WriteReg}, {27'b0, pend.wreg});
                    if (pend.chk_res) chk("W_Result", W_Result, pend.res);
                    pend_v = 0;
                end
                if (dmem_bus.dmem_req) begin
                    if (!req_seen) begin
                        req_seen = 1;
                        cb_v = (busq.size() != 0);
                        if (cb_v) cb = busq.pop_front();
                        else begin
                            total++; bad++;
                            $display("FAIL bus_unexpected: got req=1 want no request");
                        end
                    end
                    if (cb_v) begin
                        chk("dmem_addr", dmem_bus.dmem_addr, cb.addr);
                        chk("dmem_we", {31'b0, dmem_bus.dmem_we}, {31'b0, cb.we});
                        chk("dmem_be", {28'b0, dmem_bus.dmem_be}, {28'b0, cb.be});
                        if (cb.we) chk("dmem_wdata", dmem_bus.dmem_wdata, cb.wdata);
                    end
                end else begin
                    req_seen = 0;
                end
                if (Mem_Stall) begin
                    stall_cnt++;
                    chk("Mem_Err_in_stall", {31'b0, Mem_Err}, 32'd0);
                end else if (drv_valid) begin
                    if (expq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL retire_underflow: got retirement want none");
                    end else begin
                        e = expq.pop_front();
                        chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                        chk("Mem_Err", {31'b0, Mem_Err}, {31'b0, e.err});
                        pend = e;
                        pend_v = 1;
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    // Reference model over a byte-addressed memory, then drive and wait for retirement.
    task automatic issue(input bit rw, input bit mw, input bit mtr, input bit [4:0] wreg,
                         input bit [31:0] qb, input bit [31:0] alu, input bit [2:0] lopt,
                         input bit [1:0] sopt, input int wt);
        exp_t e;
        bus_t b;
        int sz, a, off, cyc;
        bit acc, st, ld, tmo;
        logic [31:0] v;
        acc = mw | mtr;
        st  = mw;
        ld  = mtr && !mw;
        if (st) sz = (sopt == 1) ? 2 : (sopt == 2) ? 1 : 4;
        else    sz = (lopt == 1 || lopt == 2) ? 2 : (lopt == 3 || lopt == 4) ? 1 : 4;
        a   = int'(alu[1:0]);
        off = int'(alu[5:0]);
        e.rw = rw; e.wreg = wreg; e.res = alu; e.chk_res = 1; e.err = 0; e.stall = 0;
        if (acc && (a % sz != 0)) begin
            e.rw = 0;
            e.err = 1;
        end else if (acc) begin
            tmo = (wt >= ACK_TO);
            e.stall = 1 + (tmo ? ACK_TO : wt + 1);
            e.err = tmo;
            e.rw = rw && !tmo;
            b.addr = alu & ~32'h3;
            b.we = st;
            b.be = 4'hF;
            b.wdata = 0;
            if (st) begin
                b.be = 0;
                for (int i = 0; i < sz; i++) b.be[a + i] = 1'b1;
                for (int j = 0; j < 4; j++) b.wdata[8*j +: 8] = qb[8*(j % sz) +: 8];
                if (!tmo) for (int i = 0; i < sz; i++) ref_bytes[off + i] = qb[8*i +: 8];
            end
            if (ld) begin
                if (tmo) e.chk_res = 0;
                else begin
                    v = 0;
                    for (int i = 0; i < sz; i++) v = v | (32'(ref_bytes[off + i]) << (8 * i));
                    if ((lopt == 1 || lopt == 3) && v[8*sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
                    e.res = v;
                end
            end
            busq.push_back(b);
        end
        expq.push_back(e);
        cur_wait = wt;
        M_RegWrite = rw; M_MemWrite = mw; M_MemtoReg = mtr; M_WriteReg = wreg;
        M_Qb = qb; M_ALUanswer = alu; M_load_option = lopt; M_save_option = sopt;
        drv_valid = 1'b1;
        cyc = 0;
        forever begin
            @(negedge Clk);
            if (!Mem_Stall) break;
            cyc++;
            if (cyc > 50) begin
                total++; bad++;
                $display("FAIL issue_bound: stall still high after %0d cycles, want low", cyc);
                break;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        bit [31:0] alu;
        int kind, wt;
        for (int k = 0; k < 64; k++) ref_bytes[k] = 8'(k * 37 + 5);

        // Reset state with an aligned load presented on the inputs.
        drive_nop();
        M_MemtoReg = 1; M_RegWrite = 1; M_ALUanswer = 32'h40;
        #7;
        chk("rst_dmem_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        chk("rst_Mem_Stall", {31'b0, Mem_Stall}, 32'd0);
        chk("rst_Mem_Err", {31'b0, Mem_Err}, 32'd0);
        chk("rst_W_RegWrite", {31'b0, W_RegWrite}, 32'd0);
        chk("rst_W_Result", W_Result, 32'd0);
        chk("rst_dmem_addr", dmem_bus.dmem_addr, 32'd0);
        drive_nop();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        issue(1, 0, 0, 5, 0, 32'h1234, 0, 0, 0);               // ALU op
        issue(0, 1, 0, 3, 32'hAB, 32'h103, 0, 2, 1);           // SB, ack on 2nd REQ cycle
        issue(0, 1, 0, 0, 32'h0080FF00, 32'h100, 0, 0, 0);     // SW preload
        issue(1, 0, 1, 9, 0, 32'h102, 3'd3, 0, 0);             // LB  -> FFFFFF80
        issue(1, 0, 1, 9, 0, 32'h102, 3'd4, 0, 2);             // LBU -> 00000080
        issue(0, 1, 0, 0, 32'h80000000, 32'h000, 0, 0, 0);     // SW preload
        issue(1, 0, 1, 10, 0, 32'h002, 3'd1, 0, ACK_TO - 1);   // LH -> FFFF8000, last-cycle ack
        issue(1, 0, 1, 11, 0, 32'h101, 0, 0, 0);               // misaligned LW
        issue(1, 0, 1, 12, 0, 32'h40, 0, 0, 1000);             // ack timeout
        issue(1, 1, 1, 13, 32'h5555AAAA, 32'h46, 3'd1, 2'd1, 0); // store wins over load

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 3);
            alu = $urandom;
            if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
            wt = ($urandom_range(0, 9) == 0) ? $urandom_range(ACK_TO, ACK_TO + 2) : $urandom_range(0, ACK_TO - 1);
            issue(1'($urandom), kind >= 2, kind == 1 || kind == 3, 5'($urandom), $urandom, alu,
                  3'($urandom), 2'($urandom), wt);
        end

        drv_valid = 1'b0;
        drive_nop();
        repeat (3) @(negedge Clk);
        chk("expq_drained", 32'(expq.size()), 32'd0);
        chk("busq_drained", 32'(busq.size()), 32'd0);

        // Asynchronous reset in the middle of REQ.
        @(posedge Clk);
        #1;
        mon_en = 1'b0;
        cur_wait = 1000;
        M_MemtoReg = 1; M_RegWrite = 1; M_WriteReg = 4; M_ALUanswer = 32'h20;
        @(negedge Clk);
        @(negedge Clk);
        chk("req_before_reset", {31'b0, dmem_bus.dmem_req}, 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        chk("reset_dmem_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        chk("reset_Mem_Stall", {31'b0, Mem_Stall}, 32'd0);
        chk("reset_W_RegWrite", {31'b0, W_RegWrite}, 32'd0);
        chk("reset_dmem_be", {28'b0, dmem_bus.dmem_be}, 32'd0);
        chk("reset_W_Result", W_Result, 32'd0);
        drive_nop();
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        mon_en = 1'b1;
        issue(1, 0, 0, 7, 0, 32'hCAFE, 0, 0, 0);
        drv_valid = 1'b0;
        drive_nop();
        repeat (3) @(negedge Clk);
        chk("final_expq_drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
